// File: rtl/seq_div16_if.sv
// rtl/seq_div16_if.sv - launch/result signal bundle for the seq_div16 divider
interface seq_div16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overF;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overF
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overF
    );
endinterface

// File: rtl/seq_div16.sv
// rtl/seq_div16.sv - iterative restoring divider; DIV_EARLY_TERM_EN enables |dividend|<|divisor| early finish
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    seq_div16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    typedef enum logic [1:0] {K_NORM, K_DZ, K_OVF, K_EARLY} kind_t;

    state_t           state;
    kind_t            kind;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic             q_neg;
    logic             r_neg;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dz_r;
    logic             ovf_r;

    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             dz_in;
    logic             ovf_in;
    logic             early_in;
    logic [WIDTH:0]   rem_sh;
    logic             take;

    always_comb begin
        mag_a_in = (bus.sign && bus.dividend[WIDTH-1]) ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        mag_b_in = (bus.sign && bus.divisor[WIDTH-1])  ? (~bus.divisor + WIDTH'(1))  : bus.divisor;
        dz_in    = (bus.divisor == '0);
        ovf_in   = bus.sign && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
`ifdef DIV_EARLY_TERM_EN
        early_in = (mag_a_in < mag_b_in);
`else
        early_in = 1'b0;
`endif
        // Partial remainder can momentarily need WIDTH+1 bits after the shift.
        rem_sh   = {rem, dq[WIDTH-1]};
        take     = (rem_sh >= {1'b0, mag_b});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            kind   <= K_NORM;
            count  <= '0;
            a_raw  <= '0;
            mag_b  <= '0;
            rem    <= '0;
            dq     <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_raw  <= bus.dividend;
                        mag_b  <= mag_b_in;
                        rem    <= '0;
                        dq     <= mag_a_in;
                        q_neg  <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg  <= bus.sign && bus.dividend[WIDTH-1];
                        count  <= '0;
                        busy_r <= 1'b1;
                        dz_r   <= 1'b0;
                        ovf_r  <= 1'b0;
                        if (dz_in) begin
                            kind  <= K_DZ;
                            state <= FIX;
                        end else if (ovf_in) begin
                            kind  <= K_OVF;
                            state <= FIX;
                        end else if (early_in) begin
                            kind  <= K_EARLY;
                            state <= FIX;
                        end else begin
                            kind  <= K_NORM;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= take ? WIDTH'(rem_sh - {1'b0, mag_b}) : rem_sh[WIDTH-1:0];
                    dq    <= {dq[WIDTH-2:0], take};
                    count <= count + CW'(1);
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    case (kind)
                        K_DZ: begin
                            quot_r <= '1;
                            rem_r  <= a_raw;
                            dz_r   <= 1'b1;
                        end
                        K_OVF: begin
                            quot_r <= {1'b1, {(WIDTH-1){1'b0}}};
                            rem_r  <= '0;
                            ovf_r  <= 1'b1;
                        end
                        K_EARLY: begin
                            quot_r <= '0;
                            rem_r  <= a_raw;
                        end
                        default: begin
                            quot_r <= q_neg ? (~dq + WIDTH'(1)) : dq;
                            rem_r  <= r_neg ? (~rem + WIDTH'(1)) : rem;
                        end
                    endcase
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overF       = ovf_r;
endmodule

// File: tb/tb_seq_div16.sv
// tb/tb_seq_div16.sv - directed self-checking bench for seq_div16
module tb_seq_div16;
    logic clk;
    logic rst;
    int   total;
    int   passed;

`ifdef DIV_EARLY_TERM_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 17;
`endif

    seq_div16_if #(.WIDTH(16)) bus ();

    seq_div16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz,
                       input logic eov, input int elat);
        int lat;
        lat = -1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
        chk({tag, " overF"}, 32'(bus.overF), 32'(eov));
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse_ends"}, 32'(bus.done), 32'd0);
        chk({tag, " quotient_held"}, 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        int seen;
        total        = 0;
        passed       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset quotient", 32'(bus.quotient), 32'd0);
        chk("reset remainder", 32'(bus.remainder), 32'd0);
        chk("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        chk("reset overF", 32'(bus.overF), 32'd0);
        rst = 1'b0;

        run("u100/7", 1'b0, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0, 17);
        run("s-100/7", 1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
        run("s100/-7", 1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17);
        run("s-7/2", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17);
        run("u_dz", 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);
        run("s_dz", 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);
        run("s_ovf", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1);
        run("u8000/FFFF", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, EARLY_LAT);
        run("uFFFF/1", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);

        // Abort with reset on the 5th CALC edge; prior result is nonzero so clearing is visible.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.sign     = 1'b0;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort quotient", 32'(bus.quotient), 32'd0);
        chk("abort remainder", 32'(bus.remainder), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort no_done", 32'(seen), 32'd0);

        // 9/3 with start held high (and operands changed) while busy.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.sign     = 1'b0;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("9/3 latency", 32'(lat), 32'd17);
        chk("9/3 quotient", 32'(bus.quotient), 32'd3);
        chk("9/3 remainder", 32'(bus.remainder), 32'd0);
        @(posedge clk);
        #1;
        chk("9/3 no_requeue", 32'(bus.busy), 32'd0);

        run("u3/10", 1'b0, 16'd3, 16'd10, 16'h0000, 16'h0003, 1'b0, 1'b0, EARLY_LAT);
        run("s-3/10", 1'b1, 16'hFFFD, 16'd10, 16'h0000, 16'hFFFD, 1'b0, 1'b0, EARLY_LAT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
